// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: sequencing controls going into the PC unit and the
// fetch address/status coming back out towards instruction memory.
interface pc_fetch_if;
    logic       start;
    logic       stall;
    logic       branch_en;
    logic [2:0] branch_offset;
    logic       jump_en;
    logic [7:0] jump_target;
    logic       halt_req;
    logic [7:0] instruction_input_index;
    logic       fetch_valid;
    logic       halted;
    logic [7:0] fetch_count;

    modport master (
        output start, stall, branch_en, branch_offset, jump_en, jump_target, halt_req,
        input  instruction_input_index, fetch_valid, halted, fetch_count
    );

    modport slave (
        input  start, stall, branch_en, branch_offset, jump_en, jump_target, halt_req,
        output instruction_input_index, fetch_valid, halted, fetch_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer for the 8-bit processor. Produces the
// instruction memory index, handles increment, PC-relative branch and
// absolute jump, and stops permanently on a halt request or an out-of-range
// next address. Exit from HALT is by reset only.
module pc_fetch_unit #(
    parameter logic [7:0] RESET_ADDR = 8'd0,
    parameter logic [7:0] MAX_ADDR   = 8'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_fetch_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic       rst_meta_r;
    logic       rst_sync_r;
    logic [1:0] state_r,  state_s;
    logic [7:0] index_r,  index_s;
    logic       valid_r,  valid_s;
    logic       halted_r, halted_s;
    logic [7:0] count_r;
    logic [7:0] target_s;

    // Candidate next PC in RUN: jump beats branch, branch beats increment.
    // All arithmetic wraps mod 256 so a backward branch below 0 lands high
    // and is then caught by the range check.
    function automatic logic [7:0] calc_next_pc(
        input logic [7:0] pc,
        input logic       jmp,
        input logic [7:0] jmp_tgt,
        input logic       br,
        input logic [2:0] br_off
    );
        logic [7:0] result;
        if (jmp) begin
            result = jmp_tgt;
        end else if (br) begin
            result = pc + 8'd1 + {{5{br_off[2]}}, br_off};
        end else begin
            result = pc + 8'd1;
        end
        return result;
    endfunction

    // Reset release synchronizer: assertion is immediate, release takes two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Next-state and next-output decode for the IDLE/RUN/HALT sequencer.
    always_comb begin
        state_s  = state_r;
        index_s  = index_r;
        valid_s  = 1'b0;
        halted_s = halted_r;
        target_s = calc_next_pc(index_r, bus.jump_en, bus.jump_target,
                                bus.branch_en, bus.branch_offset);
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                    index_s = RESET_ADDR;
                    valid_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_s  = ST_HALT;
                    halted_s = 1'b1;
                end else if (bus.stall) begin
                    // Redirects arriving during a stall are dropped on purpose.
                    valid_s = 1'b0;
                end else if (target_s > MAX_ADDR) begin
                    // Index keeps the last legal address for post-mortem.
                    state_s  = ST_HALT;
                    halted_s = 1'b1;
                end else begin
                    index_s = target_s;
                    valid_s = 1'b1;
                end
            end
            ST_HALT: begin
                valid_s  = 1'b0;
                halted_s = 1'b1;
            end
            default: begin
                state_s  = ST_IDLE;
                index_s  = RESET_ADDR;
                valid_s  = 1'b0;
                halted_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered fetch outputs.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            state_r  <= ST_IDLE;
            index_r  <= RESET_ADDR;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            index_r  <= index_s;
            valid_r  <= valid_s;
            halted_r <= halted_s;
        end
    end

    // Saturating count of cycles that carried a live fetch.
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            count_r <= 8'd0;
        end else if (valid_r && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign bus.instruction_input_index = index_r;
    assign bus.fetch_valid             = valid_r;
    assign bus.halted                  = halted_r;
    assign bus.fetch_count             = count_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven bench for pc_fetch_unit: each record holds one cycle of
// stimulus plus the outputs expected after that edge; expectations go through
// a scoreboard queue and are checked one cycle later.
module tb_pc_fetch_unit;

    typedef struct {
        logic       do_reset;
        logic       start;
        logic       stall;
        logic       br_en;
        logic [2:0] br_off;
        logic       j_en;
        logic [7:0] j_tgt;
        logic       halt;
        logic [7:0] e_idx;
        logic       e_v;
        logic       e_h;
        logic [7:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    pc_fetch_if bus();

    pc_fetch_unit #(.RESET_ADDR(8'd0), .MAX_ADDR(8'd9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rs, input logic st, input logic sl,
                                input logic be, input logic [2:0] bo,
                                input logic je, input logic [7:0] jt, input logic hr,
                                input logic [7:0] ei, input logic ev, input logic eh,
                                input logic [7:0] ec);
        vec_t r;
        r.do_reset = rs; r.start = st; r.stall = sl; r.br_en = be; r.br_off = bo;
        r.j_en = je; r.j_tgt = jt; r.halt = hr;
        r.e_idx = ei; r.e_v = ev; r.e_h = eh; r.e_cnt = ec;
        return r;
    endfunction

    task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %0d expected %0d", nm, id, act, exp);
    endtask

    task automatic drive_idle();
        bus.start = 1'b0; bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_offset = 3'd0;
        bus.jump_en = 1'b0; bus.jump_target = 8'd0; bus.halt_req = 1'b0;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset(input int id);
        @(negedge clk);
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_index", id, bus.instruction_input_index, 8'd0);
        chk("rst_valid", id, {7'd0, bus.fetch_valid}, 8'd0);
        chk("rst_halted", id, {7'd0, bus.halted}, 8'd0);
        chk("rst_count", id, bus.fetch_count, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic step(input int id, input vec_t v);
        vec_t e;
        @(negedge clk);
        bus.start = v.start; bus.stall = v.stall; bus.branch_en = v.br_en;
        bus.branch_offset = v.br_off; bus.jump_en = v.j_en; bus.jump_target = v.j_tgt;
        bus.halt_req = v.halt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", id, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            chk("index", id, bus.instruction_input_index, e.e_idx);
            chk("fetch_valid", id, {7'd0, bus.fetch_valid}, {7'd0, e.e_v});
            chk("halted", id, {7'd0, bus.halted}, {7'd0, e.e_h});
            chk("fetch_count", id, bus.fetch_count, e.e_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drive_idle();

        // Sequential run to MAX_ADDR, then out-of-range halt; HALT ignores start/jump.
        tbl.push_back(mk(1,1,0,0,3'd0,0,8'd0,0, 8'd0,1,0,8'd0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(0,0,0,0,3'd0,0,8'd0,0, k[7:0],1,0,k[7:0]));
        tbl.push_back(mk(0,0,0,0,3'd0,0,8'd0,0, 8'd9,0,1,8'd10));
        tbl.push_back(mk(0,1,0,0,3'd0,0,8'd0,0, 8'd9,0,1,8'd10));
        tbl.push_back(mk(0,0,0,1,3'b011,1,8'd2,0, 8'd9,0,1,8'd10));

        // IDLE holds without start; branches, jump-over-branch, stall, bad jump.
        tbl.push_back(mk(1,0,0,0,3'd0,0,8'd0,0, 8'd0,0,0,8'd0));
        tbl.push_back(mk(0,1,0,0,3'd0,0,8'd0,0, 8'd0,1,0,8'd0));
        tbl.push_back(mk(0,0,0,0,3'd0,0,8'd0,0, 8'd1,1,0,8'd1));
        tbl.push_back(mk(0,0,0,0,3'd0,0,8'd0,0, 8'd2,1,0,8'd2));
        tbl.push_back(mk(0,0,0,0,3'd0,0,8'd0,0, 8'd3,1,0,8'd3));
        tbl.push_back(mk(0,0,0,1,3'b110,0,8'd0,0, 8'd2,1,0,8'd4));
        tbl.push_back(mk(0,0,0,1,3'b011,0,8'd0,0, 8'd6,1,0,8'd5));
        tbl.push_back(mk(0,0,0,0,3'd0,1,8'd1,0, 8'd1,1,0,8'd6));
        tbl.push_back(mk(0,0,0,1,3'b001,1,8'd7,0, 8'd7,1,0,8'd7));
        tbl.push_back(mk(0,0,0,0,3'd0,1,8'd4,0, 8'd4,1,0,8'd8));
        tbl.push_back(mk(0,0,1,0,3'd0,1,8'd0,0, 8'd4,0,0,8'd9));
        tbl.push_back(mk(0,0,1,0,3'd0,1,8'd0,0, 8'd4,0,0,8'd9));
        tbl.push_back(mk(0,0,0,0,3'd0,0,8'd0,0, 8'd5,1,0,8'd9));
        tbl.push_back(mk(0,0,0,0,3'd0,1,8'd12,0, 8'd5,0,1,8'd10));

        // Halt beats stall; later start is ignored.
        tbl.push_back(mk(1,1,0,0,3'd0,0,8'd0,0, 8'd0,1,0,8'd0));
        tbl.push_back(mk(0,0,0,0,3'd0,1,8'd5,0, 8'd5,1,0,8'd1));
        tbl.push_back(mk(0,0,1,0,3'd0,0,8'd0,1, 8'd5,0,1,8'd2));
        tbl.push_back(mk(0,1,0,0,3'd0,0,8'd0,0, 8'd5,0,1,8'd2));
        tbl.push_back(mk(0,0,0,0,3'd0,0,8'd0,0, 8'd5,0,1,8'd2));

        // Reach index 6, then reset mid-run; after restart a wrapping branch halts.
        tbl.push_back(mk(1,1,0,0,3'd0,0,8'd0,0, 8'd0,1,0,8'd0));
        tbl.push_back(mk(0,0,0,0,3'd0,1,8'd6,0, 8'd6,1,0,8'd1));
        tbl.push_back(mk(1,1,0,0,3'd0,0,8'd0,0, 8'd0,1,0,8'd0));
        tbl.push_back(mk(0,0,0,1,3'b100,0,8'd0,0, 8'd0,0,1,8'd1));

        foreach (tbl[i]) begin
            if (tbl[i].do_reset) do_reset(i);
            step(i, tbl[i]);
        end

        if (exp_q.size() != 0) chk("scoreboard_leftover", 0, exp_q.size(), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
